// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART start-bit front end.
// Holds the detector state encoding and the default window and tick sizes.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WINDOW   = 2'd1,
        DETECTED = 2'd2
    } det_state_e;

    localparam int DEF_INTERVAL        = 10;
    localparam int DEF_SAMPLES_PER_BIT = 8;
    localparam int DEF_MIN_LOW_SAMPLES = 4;

endpackage

// File: rtl/pulse_generator.sv
// Free-running oversampling tick: one-clock pulse every INTERVAL clocks.
// Registered output; the first pulse arrives on the INTERVAL-th clock after reset release.
module pulse_generator #(
    parameter int INTERVAL = 10
) (
    input  logic clk,
    input  logic rst,
    output logic out
);

    localparam int CW = $clog2(INTERVAL);
    localparam logic [CW-1:0] LAST = CW'(INTERVAL - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        // Registered from the next count so the pulse coincides with cnt_q == LAST.
        out_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/start_bit_detector.sv
// Qualifies a start bit by counting low samples over one bit-window of ticks.
// Sticky result, registered: visible the cycle after the window's final tick.
module start_bit_detector
    import uart_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = DEF_SAMPLES_PER_BIT,
    parameter int MIN_LOW_SAMPLES = DEF_MIN_LOW_SAMPLES
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_trigger,
    input  logic data,
    output logic start_bit_detected
);

    localparam int CW = $clog2(SAMPLES_PER_BIT + 1);
    localparam logic [CW-1:0] WIN_LEN = CW'(SAMPLES_PER_BIT);
    localparam logic [CW-1:0] MIN_LOW = CW'(MIN_LOW_SAMPLES);

    det_state_e    state_q, state_d;
    logic [CW-1:0] sample_count_q, sample_count_d;
    logic [CW-1:0] low_count_q, low_count_d;
    logic          det_q, det_d;

    always_comb begin
        state_d        = state_q;
        sample_count_d = sample_count_q;
        low_count_d    = low_count_q;

        case (state_q)
            IDLE: begin
                if (sample_trigger && !data) begin
                    state_d        = WINDOW;
                    sample_count_d = CW'(1);
                    low_count_d    = CW'(1);
                end
            end
            WINDOW: begin
                if (sample_trigger) begin
                    sample_count_d = sample_count_q + 1'b1;
                    low_count_d    = low_count_q + CW'(!data);
                end
            end
            DETECTED: state_d = DETECTED;
            default:  state_d = IDLE;
        endcase

        // Window close is evaluated on the updated counts, so it also covers a one-sample window.
        if (state_d == WINDOW && sample_count_d == WIN_LEN) begin
            state_d        = (low_count_d >= MIN_LOW) ? DETECTED : IDLE;
            sample_count_d = '0;
            low_count_d    = '0;
        end

        det_d = (state_d == DETECTED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            sample_count_q <= '0;
            low_count_q    <= '0;
            det_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            sample_count_q <= sample_count_d;
            low_count_q    <= low_count_d;
            det_q          <= det_d;
        end
    end

    assign start_bit_detected = det_q;

endmodule

// File: rtl/uart_start_bit_detector.sv
// UART RX front end: tick source alongside the start-bit detector; tick exported for the bit sampler.
// Detection is registered; no backpressure, the sticky flag holds until reset.
module uart_start_bit_detector
    import uart_pkg::*;
#(
    parameter int INTERVAL        = DEF_INTERVAL,
    parameter int SAMPLES_PER_BIT = DEF_SAMPLES_PER_BIT,
    parameter int MIN_LOW_SAMPLES = DEF_MIN_LOW_SAMPLES
) (
    input  logic clk,
    input  logic rst,
    input  logic data,
    output logic out,
    output logic start_bit_detected
);

    logic tick;

    pulse_generator #(
        .INTERVAL(INTERVAL)
    ) u_pulse_generator (
        .clk (clk),
        .rst (rst),
        .out (tick)
    );

    start_bit_detector #(
        .SAMPLES_PER_BIT(SAMPLES_PER_BIT),
        .MIN_LOW_SAMPLES(MIN_LOW_SAMPLES)
    ) u_start_bit_detector (
        .clk                (clk),
        .rst                (rst),
        .sample_trigger     (tick),
        .data               (data),
        .start_bit_detected (start_bit_detected)
    );

    assign out = tick;

endmodule

// File: tb/tb_uart_start_bit_detector.sv
// Scenario bench for the UART start-bit front end with a per-tick expected-value queue.
module tb_uart_start_bit_detector;

    localparam int INTERVAL = 10;
    localparam int TICK_BOUND = 2 * INTERVAL + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic data = 1'b1;
    logic out;
    logic det;

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_q[$];

    uart_start_bit_detector #(
        .INTERVAL(INTERVAL),
        .SAMPLES_PER_BIT(8),
        .MIN_LOW_SAMPLES(4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .data               (data),
        .out                (out),
        .start_bit_detected (det)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b0;
        data = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    // Drive one serial sample, let the next tick consume it, then compare the detector flag.
    task automatic tick(input logic v, input bit e, input string tag);
        bit ex;
        bit seen;
        exp_q.push_back(e);
        data = v;
        seen = 1'b0;
        for (int i = 0; i < TICK_BOUND && !seen; i++) begin
            @(negedge clk);
            if (out === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            ex = exp_q.pop_front();
            $display("FAIL %s timeout: no tick within %0d clocks (required one)", tag, TICK_BOUND);
            return;
        end
        @(posedge clk);
        #1;
        ex = exp_q.pop_front();
        n_cmp++;
        if (det !== ex) begin
            n_bad++;
            $display("FAIL %s: start_bit_detected=%b required %b", tag, det, ex);
        end
    endtask

    task automatic hold(input int n, input bit e, input bit wiggle, input string tag);
        int   bad;
        logic last;
        bad  = 0;
        last = det;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (wiggle) data = 1'($urandom_range(0, 1));
            if (det !== e) begin
                bad++;
                last = det;
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s: start_bit_detected=%b on %0d of %0d clocks, required %b", tag, last, bad, n, e);
        end
        data = 1'b1;
    endtask

    task automatic test_reset();
        int bad_det;
        int bad_out;
        rst = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            data    = (pass == 0) ? 1'b1 : 1'b0;
            bad_det = 0;
            bad_out = 0;
            repeat (200) begin
                @(negedge clk);
                if (det !== 1'b0) bad_det++;
                if (out !== 1'b0) bad_out++;
            end
            n_cmp += 2;
            if (bad_det != 0) begin
                n_bad++;
                $display("FAIL reset_det data=%b: det high on %0d clocks, required 0", data, bad_det);
            end
            if (bad_out != 0) begin
                n_bad++;
                $display("FAIL reset_out data=%b: out high on %0d clocks, required 0", data, bad_out);
            end
        end
        data = 1'b1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_four_low_four_high();
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, "4lo4hi_low");
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, "4lo4hi_high");
        tick(1'b1, 1'b1, "4lo4hi_final");
        hold(500, 1'b1, 1'b1, "4lo4hi_sticky");
    endtask

    task automatic test_eight_low();
        do_reset();
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, "8lo_early");
        tick(1'b0, 1'b1, "8lo_final");
        hold(500, 1'b1, 1'b1, "8lo_sticky");
    endtask

    task automatic test_glitch();
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, "glitch_low");
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, "glitch_high");
        hold(500, 1'b0, 1'b0, "glitch_rejected");
    endtask

    task automatic test_glitch_then_valid();
        do_reset();
        for (int i = 0; i < 3; i++)  tick(1'b0, 1'b0, "gv_glitch");
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, "gv_idle");
        for (int i = 0; i < 7; i++)  tick(1'b0, 1'b0, "gv_low");
        tick(1'b0, 1'b1, "gv_final");
        hold(100, 1'b1, 1'b1, "gv_sticky");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, "b2b_glitch");
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, "b2b_close");
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, "b2b_low");
        tick(1'b0, 1'b1, "b2b_final");
    endtask

    task automatic test_scattered();
        logic pat_a [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 8; i++) tick(pat_a[i], 1'b0, "scatter3");
        hold(100, 1'b0, 1'b0, "scatter3_idle");
        do_reset();
        for (int i = 0; i < 8; i++) tick(1'(i % 2), (i == 7) ? 1'b1 : 1'b0, "scatter4");
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, "mid_low");
        #3 rst = 1'b0;
        #1;
        n_cmp++;
        if (det !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_async: det=%b required 0", det);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, "mid_fresh");
        tick(1'b0, 1'b1, "mid_fresh_final");
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (det !== 1'b0) begin
            n_bad++;
            $display("FAIL detected_reset_async: det=%b required 0", det);
        end
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        data = 1'b1;
    endtask

    task automatic test_pulse_gen();
        logic ex;
        do_reset();
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            ex = ((n % INTERVAL) == INTERVAL - 1) ? 1'b1 : 1'b0;
            n_cmp++;
            if (out !== ex) begin
                n_bad++;
                $display("FAIL pulse_gen clk%0d: out=%b required %b", n, out, ex);
            end
        end
    endtask

    initial begin
        test_reset();
        test_four_low_four_high();
        test_eight_low();
        test_glitch();
        test_glitch_then_valid();
        test_back_to_back();
        test_scattered();
        test_reset_mid();
        test_pulse_gen();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_start_bit_detector.md
# uart_start_bit_detector

UART receive front end that qualifies a start bit on an idle-high serial line, using a periodic oversampling tick. It contains the `start_bit_detector` core and its companion tick source, the `pulse_generator`. The detector evaluates one bit-window of samples and rejects short glitches. On a valid start bit it raises a sticky flag that the downstream bit sampler uses to begin frame capture.

## Interface
Parameters:
- `INTERVAL`, default 10 (`pulse_generator`): clocks per tick; must be ≥ 2.
- `SAMPLES_PER_BIT`, default 8 (`start_bit_detector`): ticks in one evaluation window.
- `MIN_LOW_SAMPLES`, default 4 (`start_bit_detector`): low samples in the window required to accept a start bit.

`pulse_generator` ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `out`  out  1  one-clock-wide tick, every `INTERVAL` clocks.

`start_bit_detector` ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `sample_trigger`  in  1  oversampling tick from `pulse_generator`.
- `data`  in  1  serial RX line, idle high, already synchronous to `clk`.
- `start_bit_detected`  out  1  sticky start-bit-accepted flag.

## Operation
`pulse_generator`:
- Counter width is `$clog2(INTERVAL)`. The counter is 0 in reset and increments every clock.
- It wraps to 0 after reaching `INTERVAL-1`.
- `out` is a registered output, high for exactly the one clock when the counter equals `INTERVAL-1`.
- `out` is low in reset and low during the first `INTERVAL-1` clocks after reset release.

`start_bit_detector` FSM states:
- IDLE: on a clock with `sample_trigger`=1 and `data`=0, go to WINDOW with sample_count=1 and low_count=1. Otherwise stay in IDLE.
- WINDOW: on each clock with `sample_trigger`=1, sample_count++, and low_count++ if `data`=0. Clocks without a trigger are ignored.
- When sample_count reaches `SAMPLES_PER_BIT`:
  - low_count ≥ `MIN_LOW_SAMPLES` → go to DETECTED.
  - Otherwise → go to IDLE and clear both counters.
- DETECTED: absorbing state. `start_bit_detected`=1 until reset; `data` and `sample_trigger` are ignored.

Boundary conditions:
- Low samples in a window do not need to be contiguous. Only the total count matters.
- A rejected window returns to IDLE. The next low sample opens a new window, which may occur on the very next tick.
- Counter widths are `$clog2(SAMPLES_PER_BIT+1)`. Counters cannot overflow because the window closes at `SAMPLES_PER_BIT`.
- Reset asserted at any time, including mid-window or in DETECTED, immediately forces IDLE, zeroes both counters and clears the output. The same holds while `data`=0.

## Timing
- Reset values: `out`=0 and `start_bit_detected`=0, with the FSM in IDLE.
- `start_bit_detected` is registered. It rises on the clock edge that consumes the `SAMPLES_PER_BIT`-th tick of an accepting window, and is visible from the following cycle.
- The output is never asserted before the window's final tick, even when all samples so far are low.
- Detection latency from the first low sample is (`SAMPLES_PER_BIT`-1) tick periods plus 1 clock.

## Structure
- A shared package `uart_pkg` holds the detector state enum (IDLE, WINDOW, DETECTED) and the default constants 8 and 4.
- `pulse_generator` is a standalone sub-module. It is instantiated alongside the detector, not inside it, so one tick source can serve both the detector and the downstream bit sampler.

## Test plan
All scenarios use `INTERVAL`=10, data idle 1, and data changes aligned just after a tick.
- Hold `rst` asserted for 400 clocks, with `data`=1 and then `data`=0 → `start_bit_detected` stays 0 and `out` stays 0.
- `data`=0 for 4 ticks, then 1 for 4 ticks → output stays 0 through the 8th tick edge, then is 1 for the following 500 clocks.
- `data`=0 for 8 ticks → output stays 0 through the 8th tick, rises 1 clock later, and stays 1 for 500 clocks.
- `data`=0 for 3 ticks, then 1 → output stays 0 for 500 clocks (glitch rejected).
- 3-tick glitch, then 10 high ticks, then 8 low ticks → output stays 0 until the 8th low tick, then stays 1.
- `pulse_generator` free-running for 100 clocks → `out` pulses are exactly 1 clock wide and spaced 10 clocks apart, with the first pulse on clock 10 after reset release.
